// File: rtl/timer_pkg.sv
// Shared types and helpers for the mm:ss cook timer (mmss_timer).
package timer_pkg;

  localparam int unsigned BCD_W        = 4;
  localparam int unsigned DIGIT_MAX    = 9;
  localparam int unsigned SEC_TENS_MAX = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  // Digit position 1 is tens-of-seconds (0-5); every other position is 0-9.
  function automatic int unsigned digit_max(input int unsigned idx);
    return (idx == 1) ? SEC_TENS_MAX : DIGIT_MAX;
  endfunction

  function automatic logic bcd_valid(input logic [BCD_W-1:0] d, input int unsigned idx);
    return d <= BCD_W'(digit_max(idx));
  endfunction

endpackage

// File: rtl/bcd_digit_ctr.sv
// One BCD digit of the timer chain: loadable, steps up or down with wrap at MAX.
module bcd_digit_ctr
  import timer_pkg::*;
#(
  parameter int unsigned MAX = DIGIT_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] up_val_c,
  output logic [BCD_W-1:0] dn_val_c,
  output logic             carry_c,
  output logic             borrow_c
);

  localparam logic [BCD_W-1:0] MAX_V = BCD_W'(MAX);

  // carry_c/borrow_c flag that a step in that direction would ripple onward.
  assign carry_c  = (digit == MAX_V);
  assign borrow_c = (digit == '0);
  assign up_val_c = carry_c  ? '0    : digit + BCD_W'(1);
  assign dn_val_c = borrow_c ? MAX_V : digit - BCD_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (inc) begin
      digit <= up_val_c;
    end else if (dec) begin
      digit <= dn_val_c;
    end
  end

endmodule

// File: rtl/mmss_timer.sv
// BCD mm:ss up/down cook timer with pause, done pulse, latched alarm and program check.
// Optional: define MMSS_AUTO_RELOAD_EN to reload the start value at terminal instead of expiring.
module mmss_timer
  import timer_pkg::*;
#(
  parameter  int unsigned MIN_DIGITS = 2,
  localparam int unsigned W          = BCD_W * (MIN_DIGITS + 2)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         count_enable,
  input  logic         main_enable,
  input  logic         direction,
  input  logic         load,
  input  logic [W-1:0] prog,
  input  logic         alarm_clear,
  output logic [W-1:0] count,
  output logic         running,
  output logic         done,
  output logic         alarm,
  output logic         prog_err
);

  localparam int unsigned ND = MIN_DIGITS + 2;

  state_e         state_q, state_nxt;
  logic [W-1:0]   target_q, target_nxt;
  logic           dir_q, dir_nxt;
  logic           running_nxt, done_nxt, alarm_nxt, err_nxt;

  logic [ND-1:0]  carry_w, borrow_w, rip_c;
  logic [W-1:0]   up_w, dn_w;
  logic [W-1:0]   step_val_c, terminal_c, ld_val_c;
  logic           step_c, ld_c, prog_ok_c;

  assign terminal_c = dir_q ? target_q : '0;

  // Value the count would take after one step in the latched direction.
  always_comb begin
    rip_c      = '0;
    rip_c[0]   = 1'b1;
    for (int unsigned i = 1; i < ND; i++) begin
      rip_c[i] = rip_c[i-1] & (dir_q ? carry_w[i-1] : borrow_w[i-1]);
    end
    step_val_c = count;
    for (int unsigned i = 0; i < ND; i++) begin
      if (rip_c[i]) begin
        step_val_c[BCD_W*i +: BCD_W] = dir_q ? up_w[BCD_W*i +: BCD_W] : dn_w[BCD_W*i +: BCD_W];
      end
    end
  end

  always_comb begin
    prog_ok_c = 1'b1;
    for (int unsigned i = 0; i < ND; i++) begin
      prog_ok_c = prog_ok_c & bcd_valid(prog[BCD_W*i +: BCD_W], i);
    end
  end

  for (genvar g = 0; g < ND; g++) begin : g_digit
    bcd_digit_ctr #(
      .MAX(digit_max(g))
    ) u_digit (
      .clk      (clk),
      .reset    (reset),
      .inc      (step_c & dir_q & rip_c[g]),
      .dec      (step_c & ~dir_q & rip_c[g]),
      .load     (ld_c),
      .load_val (ld_val_c[BCD_W*g +: BCD_W]),
      .digit    (count[BCD_W*g +: BCD_W]),
      .up_val_c (up_w[BCD_W*g +: BCD_W]),
      .dn_val_c (dn_w[BCD_W*g +: BCD_W]),
      .carry_c  (carry_w[g]),
      .borrow_c (borrow_w[g])
    );
  end

  // Next-state, counter control and output decode.
  always_comb begin
    state_nxt  = state_q;
    target_nxt = target_q;
    dir_nxt    = dir_q;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    alarm_nxt  = alarm & ~alarm_clear;
    step_c     = 1'b0;
    ld_c       = 1'b0;
    ld_val_c   = '0;

    if (load) begin
      if (!prog_ok_c) begin
        err_nxt = 1'b1;
      end else begin
        target_nxt = prog;
        dir_nxt    = direction;
        ld_c       = 1'b1;
        ld_val_c   = direction ? '0 : prog;
        alarm_nxt  = 1'b0;
        state_nxt  = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (main_enable) begin
            if (count == terminal_c) begin
              state_nxt = EXPIRED;
              done_nxt  = 1'b1;
              alarm_nxt = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (count_enable) begin
            step_c = 1'b1;
            if (step_val_c == terminal_c) begin
              done_nxt  = 1'b1;
              alarm_nxt = 1'b1;
`ifdef MMSS_AUTO_RELOAD_EN
              ld_c      = 1'b1;
              ld_val_c  = dir_q ? '0 : target_q;
`else
              state_nxt = EXPIRED;
`endif
            end
          end
          if (!main_enable && state_nxt == RUN) begin
            state_nxt = PAUSE;
          end
        end
        PAUSE: begin
          if (main_enable) begin
            state_nxt = RUN;
          end
        end
        EXPIRED: begin
          state_nxt = EXPIRED;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    running_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      dir_q    <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
      alarm    <= 1'b0;
      prog_err <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      target_q <= target_nxt;
      dir_q    <= dir_nxt;
      running  <= running_nxt;
      done     <= done_nxt;
      alarm    <= alarm_nxt;
      prog_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mmss_timer.sv
// Scoreboard bench for mmss_timer; reference model counts in whole seconds.
module tb_mmss_timer;

  localparam int unsigned W = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic         clk = 1'b0;
  logic         reset, count_enable, main_enable, direction, load, alarm_clear;
  logic [W-1:0] prog;
  logic [W-1:0] count;
  logic         running, done, alarm, prog_err;

  mmss_timer #(.MIN_DIGITS(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .count_enable (count_enable),
    .main_enable  (main_enable),
    .direction    (direction),
    .load         (load),
    .prog         (prog),
    .alarm_clear  (alarm_clear),
    .count        (count),
    .running      (running),
    .done         (done),
    .alarm        (alarm),
    .prog_err     (prog_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] count;
    logic         running, done, alarm, prog_err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state: time held as a plain seconds count
  int m_cnt, m_tgt, m_mode;
  bit m_dir, m_alarm, m_done, m_err;
  bit rst_s, me_s;

  function automatic logic [W-1:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [W-1:0] bad_bcd(input int secs);
    logic [W-1:0] v;
    int unsigned idx;
    v   = to_bcd(secs);
    idx = $urandom_range(3, 0);
    if (idx == 1) v[4*idx +: 4] = 4'($urandom_range(15, 6));
    else          v[4*idx +: 4] = 4'($urandom_range(15, 10));
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_tgt = 0; m_dir = 0; m_mode = M_IDLE;
    m_alarm = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model(input bit ld, input bit vld, input int ps, input bit dir,
                       input bit me, input bit ce, input bit clr);
    int term;
    bit alarm_n;
    m_done = 0;
    m_err  = 0;
    if (!rst_s) begin
      model_reset();
      return;
    end
    alarm_n = m_alarm && !clr;
    term    = m_dir ? m_tgt : 0;
    if (ld) begin
      if (!vld) m_err = 1;
      else begin
        m_tgt = ps; m_dir = dir; m_cnt = dir ? 0 : ps;
        alarm_n = 0; m_mode = M_IDLE;
      end
    end else begin
      case (m_mode)
        M_IDLE: if (me) begin
          if (m_cnt == term) begin m_mode = M_EXP; m_done = 1; alarm_n = 1; end
          else m_mode = M_RUN;
        end
        M_RUN: begin
          if (ce) begin
            m_cnt = m_dir ? m_cnt + 1 : m_cnt - 1;
            if (m_cnt == term) begin
              m_done = 1; alarm_n = 1;
`ifdef MMSS_AUTO_RELOAD_EN
              m_cnt = m_dir ? 0 : m_tgt;
`else
              m_mode = M_EXP;
`endif
            end
          end
          if (m_mode == M_RUN && !me) m_mode = M_PAUSE;
        end
        M_PAUSE: if (me) m_mode = M_RUN;
        default: ;
      endcase
    end
    m_alarm = alarm_n;
  endtask

  // One clock of stimulus; the model's prediction for the coming edge is queued.
  task automatic step(input bit ld, input bit vld, input int ps, input bit dir,
                      input bit ce, input bit clr);
    exp_t e;
    @(negedge clk);
    reset        = rst_s;
    load         = ld;
    prog         = ld ? (vld ? to_bcd(ps) : bad_bcd(ps)) : W'($urandom);
    direction    = dir;
    main_enable  = me_s;
    count_enable = ce;
    alarm_clear  = clr;
    model(ld, vld, ps, dir, me_s, ce, clr);
    e.count    = to_bcd(m_cnt);
    e.running  = (m_mode == M_RUN);
    e.done     = m_done;
    e.alarm    = m_alarm;
    e.prog_err = m_err;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 1'($urandom), 0, 0);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 1'($urandom), 1, 0);
      step(0, 1, 0, 1'($urandom), 0, 0);
    end
  endtask

  task automatic do_load(input int ps, input bit dir);
    step(1, 1, ps, dir, 0, 0);
    idle(1);
  endtask

  // monitor: compare every output once per cycle against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("count",    count,        e.count);
        chk("running",  W'(running),  W'(e.running));
        chk("done",     W'(done),     W'(e.done));
        chk("alarm",    W'(alarm),    W'(e.alarm));
        chk("prog_err", W'(prog_err), W'(e.prog_err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load = 0; count_enable = 0; main_enable = 0;
    direction = 0; alarm_clear = 0; prog = '0;
    me_s = 0; rst_s = 0;
    model_reset();
    #1 reset = 1'b0;
    #2;
    chk("rst_count",   count,        '0);
    chk("rst_running", W'(running),  '0);
    chk("rst_alarm",   W'(alarm),    '0);
    chk("rst_done",    W'(done | prog_err), '0);
    idle(2);
    rst_s = 1;
    me_s  = 1;

    // 01:00 down to expiry, then extra strobes ignored
    do_load(60, 0);
    strobes(60);
    strobes(5);

    // invalid program leaves count and alarm alone; load beats a coincident strobe
    step(1, 0, 45, 0, 0, 0);
    idle(1);
    step(1, 1, 45, 0, 1, 0);
    idle(2);

    // full borrow chain, then up-count to target
    do_load(600, 0);
    strobes(1);
    do_load(10, 1);
    strobes(9);
    strobes(1);
    strobes(2);

    // pause / resume
    do_load(30, 0);
    strobes(3);
    me_s = 0;
    strobes(4);
    me_s = 1;
    idle(1);
    strobes(1);

    // asynchronous reset mid-run at 00:15
    do_load(30, 0);
    strobes(15);
    @(posedge clk);
    #3;
    rst_s = 0;
    reset = 1'b0;
    #1;
    chk("async_count",   count,       '0);
    chk("async_running", W'(running), '0);
    chk("async_alarm",   W'(alarm),   '0);
    model_reset();
    idle(2);
    rst_s = 1;
    do_load(0, 0);
    idle(2);
    step(0, 1, 0, 0, 0, 1);
    idle(1);

    // 00:03 down through terminal (reloads when auto-reload is built in)
    do_load(3, 0);
    strobes(6);
    do_load(2, 1);
    strobes(5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit ld, vld;
      int ps;
      me_s = ($urandom_range(15, 0) != 0);
      ld   = ($urandom_range(39, 0) == 0);
      vld  = ($urandom_range(4, 0) != 0);
      ps   = ($urandom_range(1, 0) == 1) ? int'($urandom_range(20, 0)) : int'($urandom_range(5999, 0));
      step(ld, vld, ps, 1'($urandom), 1'($urandom), ($urandom_range(19, 0) == 0));
    end

    idle(1);
    @(posedge clk);
    #2;
    chk("sb_drain", W'(sb_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
